pps_phase_discipline: RTL
=========================

# pps_phase_discipline

Phase-locking loop filter that sits directly upstream of the SiT5503 oscillator controller. It timestamps the reference PPS against a local PPS derived from the 10 MHz oscillator output and pairs the two edges into a signed phase error. A velocity-form PI filter turns that error into an incremental 16-bit control step, which drives the controller's `frequency_offset`/`offset_valid` inputs. The block also reports lock and holdover status.

## Interface
- `CLK_HZ`, 100_000_000: clk frequency; pairing window = CLK_HZ/2 cycles
- `KP_SHIFT`, 2: proportional gain as an arithmetic right shift of (e − e_prev)
- `KI_SHIFT`, 4: integral gain as an arithmetic right shift of e
- `MAX_STEP`, 512: symmetric clamp on each issued step
- `LOCK_THRESH`, 100: |e| in cycles that counts as in-lock
- `LOCK_COUNT`, 4: consecutive in-lock samples required to assert locked
- `TIMEOUT`, 150_000_000: cycles without a valid ref edge before entering holdover
- `DEADBAND`, 8: |e| below which no step is issued (macro-gated)
- Reset is `rst_n`, asynchronous, active-low; the clock is `clk`.
- `clk` input 1: system clock, 100 MHz
- `rst_n` input 1: asynchronous active-low reset
- `ref_pps` input 1: reference PPS, asynchronous
- `ref_valid` input 1: reference qualifier, asynchronous level
- `local_pps` input 1: PPS divided from the SiT5503 clock, asynchronous
- `enable` input 1: loop enable; when low, samples are measured but no step is issued
- `oscillator_ready` input 1: the downstream controller accepts offsets
- `frequency_offset` output 16: signed step, held between pulses
- `offset_valid` output 1: one-cycle strobe qualifying `frequency_offset`
- `phase_error` output 32: signed e of the last completed pair (local − ref)
- `locked` output 1: loop in lock
- `holdover` output 1: no usable reference
- `miss_count` output 8: count of discarded unpaired edges, saturating at 255

## Operation
- Each PPS input (and `ref_valid`) passes through a 2-FF synchronizer; each PPS then gets a rising-edge detector.
- A free-running 32-bit cycle counter provides timestamps.
- FSM states:
  - IDLE: the first edge of either kind latches its timestamp and moves to WAIT_PAIR. If both edges arrive in the same cycle, go straight to COMPUTE with e = 0.
  - WAIT_PAIR: the opposite-kind edge latches the second timestamp and moves to COMPUTE. A repeat of the same-kind edge restarts the window with the new timestamp and increments `miss_count`. If the window expires, increment `miss_count` and return to IDLE.
  - COMPUTE:
    - e = t_local − t_ref as a 32-bit two's-complement subtraction, so counter wrap is harmless.
    - e is saturated to ±CLK_HZ/2, then written to `phase_error`.
    - If this is the first sample after reset or after holdover, set e_prev = e.
  - CLAMP:
    - step = ((e − e_prev) >>> KP_SHIFT) + (e >>> KI_SHIFT).
    - step is saturated to ±MAX_STEP; then e_prev ← e.
  - ISSUE:
    - If `enable` is low, return to IDLE without a strobe.
    - Otherwise wait for `oscillator_ready`, then drive `frequency_offset` = step and pulse `offset_valid`, and return to IDLE.
    - Edges arriving in ISSUE are ignored.
  - HOLDOVER: entered from any state when synchronized `ref_valid` is low, or after TIMEOUT cycles with no ref edge. It sets `holdover` = 1, aborts any pending sample (no strobe), and freezes `frequency_offset`. It exits to IDLE on the first ref edge seen with `ref_valid` high; that ref edge is consumed as the first edge of a new pair, and the next sample re-seeds e_prev.
- Lock:
  - An in-lock counter increments on each completed sample with |e| ≤ LOCK_THRESH and clears otherwise.
  - `locked` = 1 while the counter ≥ LOCK_COUNT.
  - `locked` is cleared immediately on a sample above threshold or on entry to holdover.
- Sign convention: positive e means the local PPS is late, so the step is positive (raise frequency).

## Timing
- Reset values: `frequency_offset` 0, `offset_valid` 0, `phase_error` 0, `locked` 0, `holdover` 1, `miss_count` 0, FSM in HOLDOVER.
- Pin edge to timestamp latch: 3 clk cycles, identical for both inputs, so the skew cancels.
- Second edge detected to `offset_valid`: 3 clk cycles (COMPUTE, CLAMP, ISSUE) when `oscillator_ready` = 1; otherwise the strobe occurs on the first cycle `ready` is high.
- `offset_valid` is never asserted on two consecutive cycles.
- An asynchronous reset mid-sample returns all outputs to their reset values within the same cycle.

## Configuration
- `PPS_DISCIPLINE_DEADBAND_EN` defined: when |e| ≤ DEADBAND, CLAMP forces step = 0 and ISSUE returns to IDLE without a strobe. e_prev and lock tracking still update.
- Macro undefined: every completed sample issues a strobe, including step = 0.

## Test plan
- Ref and local edges every 1 s, local 200 cycles late, `ready` = 1: first sample e = 200, step = 12. Second sample step = 12, `offset_valid` occurs 3 cycles after the local edge.
- Local 40 cycles early on the first sample: e = −40, `frequency_offset` = −3 (0xFFFD).
- e = 20000 on the first sample: step clamps to +512. Next sample e = −20000: step clamps to −512.
- Four consecutive samples with e = 50: `locked` rises after the 4th. A 5th sample with e = 150 drops `locked` at COMPUTE+1.
- Drop `ref_valid` mid-WAIT_PAIR: `holdover` = 1, no strobe, offset frozen. Restore with e = 30: first sample step = 1 (re-seeded), `holdover` = 0.
- Local edges only, no ref for 1.5 s: `miss_count` increments per expired window and `holdover` asserts at TIMEOUT. With `oscillator_ready` = 0 during a pending sample, no strobe occurs until ready rises.

Source files
------------

// File: rtl/pps_phase_discipline.sv
// pps_phase_discipline: PPS phase detector + velocity-form PI loop filter driving frequency steps.
// Optional deadband on small errors is enabled by defining PPS_DISCIPLINE_DEADBAND_EN.
module pps_phase_discipline #(
  parameter int CLK_HZ      = 100_000_000,
  parameter int KP_SHIFT    = 2,
  parameter int KI_SHIFT    = 4,
  parameter int MAX_STEP    = 512,
  parameter int LOCK_THRESH = 100,
  parameter int LOCK_COUNT  = 4,
  parameter int TIMEOUT     = 150_000_000,
  parameter int DEADBAND    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ref_pps,
  input  logic        ref_valid,
  input  logic        local_pps,
  input  logic        enable,
  input  logic        oscillator_ready,
  output logic [15:0] frequency_offset,
  output logic        offset_valid,
  output logic [31:0] phase_error,
  output logic        locked,
  output logic        holdover,
  output logic [7:0]  miss_count
);
  localparam logic signed [31:0] HALF = 32'(CLK_HZ / 2);
  localparam logic        [31:0] WIN  = 32'(CLK_HZ / 2);
  localparam logic signed [31:0] MAXS = 32'(MAX_STEP);
  localparam logic signed [31:0] LTH  = 32'(LOCK_THRESH);
  localparam logic signed [31:0] DB   = 32'(DEADBAND);
  localparam logic        [31:0] TMO  = 32'(TIMEOUT);
  localparam logic        [8:0]  LCNT = 9'(LOCK_COUNT);
`ifdef PPS_DISCIPLINE_DEADBAND_EN
  localparam logic DB_EN = 1'b1;
`else
  localparam logic DB_EN = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, WAIT_PAIR, COMPUTE, CLAMP, ISSUE, HOLDOVER} state_t;
  state_t state;
  logic [2:0] ref_sync, loc_sync;
  logic [1:0] rv_sync;
  logic ref_e, loc_e, rv_s;
  logic [31:0] cnt, t_ref, t_loc, since_ref;
  logic signed [31:0] e, e_prev, d, e_sat, raw;
  logic [15:0] step, step_sat;
  logic [7:0] lock_cnt;
  logic seed, first_ref, skip, db, in_lock;
  assign ref_e = ref_sync[1] & ~ref_sync[2];
  assign loc_e = loc_sync[1] & ~loc_sync[2];
  assign rv_s  = rv_sync[1];
  always_comb begin
    d        = signed'(t_loc - t_ref);
    e_sat    = d > HALF ? HALF : d < -HALF ? -HALF : d;
    in_lock  = e_sat >= -LTH && e_sat <= LTH;
    raw      = ((e - e_prev) >>> KP_SHIFT) + (e >>> KI_SHIFT);
    step_sat = raw > MAXS ? 16'(MAX_STEP) : raw < -MAXS ? 16'(-MAX_STEP) : raw[15:0];
    db       = DB_EN && e >= -DB && e <= DB;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= HOLDOVER;
      ref_sync <= '0;
      loc_sync <= '0;
      rv_sync <= '0;
      cnt <= '0;
      t_ref <= '0;
      t_loc <= '0;
      since_ref <= '0;
      e <= '0;
      e_prev <= '0;
      step <= '0;
      lock_cnt <= '0;
      seed <= 1'b1;
      first_ref <= 1'b0;
      skip <= 1'b0;
      frequency_offset <= '0;
      offset_valid <= 1'b0;
      phase_error <= '0;
      locked <= 1'b0;
      holdover <= 1'b1;
      miss_count <= '0;
    end else begin
      cnt <= cnt + 32'd1;
      ref_sync <= {ref_sync[1:0], ref_pps};
      loc_sync <= {loc_sync[1:0], local_pps};
      rv_sync <= {rv_sync[0], ref_valid};
      since_ref <= ref_e ? '0 : since_ref < TMO ? since_ref + 32'd1 : since_ref;
      offset_valid <= 1'b0;
      if (state != HOLDOVER && (!rv_s || (since_ref >= TMO && !ref_e))) begin
        state <= HOLDOVER;
        holdover <= 1'b1;
        locked <= 1'b0;
        lock_cnt <= '0;
        seed <= 1'b1;
      end else begin
        case (state)
          HOLDOVER: if (ref_e && rv_s) begin
            holdover <= 1'b0;
            t_ref <= cnt;
            t_loc <= cnt;
            first_ref <= 1'b1;
            state <= loc_e ? COMPUTE : WAIT_PAIR;
          end
          // Both stamps take the first edge so the window test only needs t_ref.
          IDLE: if (ref_e || loc_e) begin
            t_ref <= cnt;
            t_loc <= cnt;
            first_ref <= ref_e;
            state <= (ref_e && loc_e) ? COMPUTE : WAIT_PAIR;
          end
          WAIT_PAIR: begin
            if (first_ref ? loc_e : ref_e) begin
              if (first_ref) t_loc <= cnt;
              else t_ref <= cnt;
              state <= COMPUTE;
            end else if (first_ref ? ref_e : loc_e) begin
              t_ref <= cnt;
              t_loc <= cnt;
              miss_count <= miss_count + {7'd0, miss_count != 8'hFF};
            end else if (cnt - t_ref >= WIN) begin
              miss_count <= miss_count + {7'd0, miss_count != 8'hFF};
              state <= IDLE;
            end
          end
          COMPUTE: begin
            e <= e_sat;
            phase_error <= e_sat;
            if (seed) e_prev <= e_sat;
            seed <= 1'b0;
            lock_cnt <= in_lock ? (lock_cnt == 8'hFF ? lock_cnt : lock_cnt + 8'd1) : '0;
            locked <= in_lock && ({1'b0, lock_cnt} + 9'd1 >= LCNT);
            state <= CLAMP;
          end
          CLAMP: begin
            step <= db ? '0 : step_sat;
            skip <= db;
            e_prev <= e;
            state <= ISSUE;
          end
          ISSUE: if (!enable || skip) state <= IDLE;
          else if (oscillator_ready) begin
            frequency_offset <= step;
            offset_valid <= 1'b1;
            state <= IDLE;
          end
          default: state <= HOLDOVER;
        endcase
      end
    end
  end
endmodule
